trace_capture_ctrl: RTL and testbench

- Run controller for the trace path: start/stop, optional PC-triggered arm, item limit.
- Gates `pc_valid` into trace_filter and aligns the PC with the filter's registered `drop_instr` (1-cycle latency).
- Issues trace FIFO writes for kept instructions only, with backpressure accounting.
- Sits between the CPU trace port, trace_filter and the trace FIFO; configured from the CMS control registers.

---
 rtl/continuous_monitoring_system_pkg.sv | 19 +
 rtl/trace_capture_ctrl.sv | 136 +++++++++++++
 tb/tb_trace_capture_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system trace path.
// The state encodings are also the values read back through the CMS register map.
package continuous_monitoring_system_pkg;

   localparam int TRACE_PC_WIDTH = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_ctrl_state_t;

   localparam logic [1:0] TRACE_STATE_IDLE    = 2'd0;
   localparam logic [1:0] TRACE_STATE_ARMED   = 2'd1;
   localparam logic [1:0] TRACE_STATE_CAPTURE = 2'd2;
   localparam logic [1:0] TRACE_STATE_DONE    = 2'd3;

endpackage

// File: rtl/trace_capture_ctrl.sv
// Trace run controller: start/stop and PC triggers, filter gating, stage-1 PC
// alignment with the filter decision, FIFO write issue and loss accounting.
module trace_capture_ctrl
   import continuous_monitoring_system_pkg::*;
#(
   parameter int PC_WIDTH    = TRACE_PC_WIDTH,
   parameter int COUNT_WIDTH = 32,
   parameter int OVF_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_start,
   input  logic                   cfg_stop,
   input  logic                   cfg_trigger_en,
   input  logic [PC_WIDTH-1:0]    cfg_start_pc,
   input  logic [PC_WIDTH-1:0]    cfg_stop_pc,
   input  logic [COUNT_WIDTH-1:0] cfg_max_items,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic                   pc_valid,
   input  logic                   drop_instr,
   input  logic                   fifo_full,
   output logic                   filter_pc_valid,
   output logic                   fifo_wr_en,
   output logic [PC_WIDTH-1:0]    fifo_wr_data,
   output logic [1:0]             state,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] item_count,
   output logic [OVF_WIDTH-1:0]   overflow_count
);

   trace_ctrl_state_t      state_q, state_d;
   logic                   cap_d1_q;
   logic [PC_WIDTH-1:0]    pc_d1_q;
   logic [COUNT_WIDTH-1:0] item_count_q, item_count_d;
   logic [OVF_WIDTH-1:0]   overflow_count_q, overflow_count_d;
   logic                   done_q, done_d;

   logic start_match_s, stop_match_s, limit_en_s, limit_hit_s, limit_next_s;
   logic start_go_s, kept_s, wr_en_s;

   assign start_match_s = pc_valid && (pc == cfg_start_pc);
   assign stop_match_s  = cfg_trigger_en && pc_valid && (pc == cfg_stop_pc);
   assign limit_en_s    = (cfg_max_items != '0);
   assign limit_hit_s   = limit_en_s && (item_count_q == cfg_max_items);
   assign limit_next_s  = limit_en_s &&
                          ((item_count_q + COUNT_WIDTH'(wr_en_s)) == cfg_max_items);

   // A restart clears the counters, so it also retires whatever sits in stage 1.
   assign start_go_s = cfg_start && !cfg_stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign kept_s     = cap_d1_q && !drop_instr && !limit_hit_s && !start_go_s;
   assign wr_en_s    = kept_s && !fifo_full;

   assign filter_pc_valid = pc_valid &&
                            ((state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && start_match_s));
   assign fifo_wr_en      = wr_en_s;
   assign fifo_wr_data    = pc_d1_q;
   assign state           = state_q;
   assign busy            = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign done            = done_q;
   assign item_count      = item_count_q;
   assign overflow_count  = overflow_count_q;

   // Next-state, counter update and done-pulse logic.
   always_comb begin
      state_d          = state_q;
      item_count_d     = item_count_q;
      overflow_count_d = overflow_count_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (cfg_stop) begin
               state_d = ST_IDLE;
            end else if (cfg_start) begin
               state_d = cfg_trigger_en ? ST_ARMED : ST_CAPTURE;
            end else begin
               state_d = state_q;
            end
         end
         ST_ARMED: begin
            if (cfg_stop) begin
               state_d = ST_IDLE;
            end else if (start_match_s) begin
               state_d = ST_CAPTURE;
            end else begin
               state_d = ST_ARMED;
            end
         end
         ST_CAPTURE: begin
            if (cfg_stop || stop_match_s || limit_next_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_go_s) begin
         item_count_d     = '0;
         overflow_count_d = '0;
      end else begin
         if (wr_en_s) begin
            item_count_d = item_count_q + COUNT_WIDTH'(1);
         end else begin
            item_count_d = item_count_q;
         end
         if (kept_s && fifo_full && (overflow_count_q != {OVF_WIDTH{1'b1}})) begin
            overflow_count_d = overflow_count_q + OVF_WIDTH'(1);
         end else begin
            overflow_count_d = overflow_count_q;
         end
      end

      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   // State, counters and the stage-1 PC pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         cap_d1_q         <= 1'b0;
         pc_d1_q          <= '0;
         item_count_q     <= '0;
         overflow_count_q <= '0;
         done_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         cap_d1_q         <= filter_pc_valid;
         pc_d1_q          <= pc;
         item_count_q     <= item_count_d;
         overflow_count_q <= overflow_count_d;
         done_q           <= done_d;
      end
   end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl; a second instance with a 3-bit loss
// counter exercises saturation without tens of thousands of cycles.
module tb_trace_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_start, cfg_stop, cfg_trigger_en;
   logic [63:0] cfg_start_pc, cfg_stop_pc;
   logic [31:0] cfg_max_items;
   logic [63:0] pc;
   logic        pc_valid, drop_instr, fifo_full;

   logic        filter_pc_valid, fifo_wr_en, busy, done;
   logic [63:0] fifo_wr_data;
   logic [1:0]  state;
   logic [31:0] item_count;
   logic [15:0] overflow_count;

   logic        s_filter_pc_valid, s_fifo_wr_en, s_busy, s_done;
   logic [63:0] s_fifo_wr_data;
   logic [1:0]  s_state;
   logic [31:0] s_item_count;
   logic [2:0]  s_overflow_count;

   int checks = 0;
   int errors = 0;
   logic [63:0] wr_log[$];
   logic [63:0] filt_log[$];
   int done_cnt = 0;
   int wb, fb, db, j;

   trace_capture_ctrl #(.PC_WIDTH(64), .COUNT_WIDTH(32), .OVF_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_trigger_en(cfg_trigger_en), .cfg_start_pc(cfg_start_pc), .cfg_stop_pc(cfg_stop_pc),
      .cfg_max_items(cfg_max_items), .pc(pc), .pc_valid(pc_valid), .drop_instr(drop_instr),
      .fifo_full(fifo_full), .filter_pc_valid(filter_pc_valid), .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data), .state(state), .busy(busy), .done(done),
      .item_count(item_count), .overflow_count(overflow_count)
   );

   trace_capture_ctrl #(.PC_WIDTH(64), .COUNT_WIDTH(32), .OVF_WIDTH(3)) u_dut_small (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_trigger_en(cfg_trigger_en), .cfg_start_pc(cfg_start_pc), .cfg_stop_pc(cfg_stop_pc),
      .cfg_max_items(cfg_max_items), .pc(pc), .pc_valid(pc_valid), .drop_instr(drop_instr),
      .fifo_full(fifo_full), .filter_pc_valid(s_filter_pc_valid), .fifo_wr_en(s_fifo_wr_en),
      .fifo_wr_data(s_fifo_wr_data), .state(s_state), .busy(s_busy), .done(s_done),
      .item_count(s_item_count), .overflow_count(s_overflow_count)
   );

   always #5 clk = ~clk;

   // Log writes, filter-presented PCs and done pulses mid-cycle.
   always @(negedge clk) begin
      if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
      if (filter_pc_valid) filt_log.push_back(pc);
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic pulse_stop();
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
   endtask

   // n kept PCs followed by one idle cycle so stage 1 drains.
   task automatic present(input int n, input logic [63:0] base);
      for (int k = 0; k < n; k++) begin
         pc = base + 64'(4 * k);
         pc_valid = 1'b1;
         drop_instr = 1'b0;
         tick();
      end
      pc_valid = 1'b0;
      tick();
   endtask

   function automatic logic [63:0] logged(input int idx);
      return (idx < wr_log.size()) ? wr_log[idx] : 64'hDEAD_DEAD;
   endfunction

   initial begin
      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_stop = 1'b0; cfg_trigger_en = 1'b0;
      cfg_start_pc = 64'h0; cfg_stop_pc = 64'h0; cfg_max_items = 32'd0;
      pc = 64'h0; pc_valid = 1'b0; drop_instr = 1'b0; fifo_full = 1'b0;
      tick(); tick();
      check("rst_state", state, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_item", item_count, 32'd0);
      check("rst_ovf", overflow_count, 16'd0);
      check("rst_wr_en", fifo_wr_en, 1'b0);
      check("rst_wr_data", fifo_wr_data, 64'd0);
      rst_n = 1'b1;
      tick();

      // 1: free-running capture, drops on PCs 2 and 5
      wb = wr_log.size();
      pulse_start();
      #2;
      check("t1_state", state, 2'd2);
      check("t1_busy", busy, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         pc = 64'(i);
         pc_valid = 1'b1;
         drop_instr = (i - 1 == 2) || (i - 1 == 5);
         tick();
      end
      pc_valid = 1'b0;
      drop_instr = 1'b0;
      tick(); tick();
      check("t1_nwr", 64'(wr_log.size() - wb), 64'd8);
      check("t1_item", item_count, 32'd8);
      j = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i != 2 && i != 5) begin
            check("t1_wr_data", logged(wb + j), 64'(i));
            j++;
         end
      end
      pulse_stop();
      #2;
      check("t1_done_state", state, 2'd3);
      check("t1_done_pulse", done, 1'b1);
      tick();
      check("t1_done_low", done, 1'b0);
      pulse_stop();
      #2;
      check("t1_idle", state, 2'd0);

      // 2: start/stop PC triggers
      cfg_trigger_en = 1'b1;
      cfg_start_pc = 64'h1000;
      cfg_stop_pc = 64'h1010;
      wb = wr_log.size(); fb = filt_log.size(); db = done_cnt;
      pulse_start();
      #2;
      check("t2_armed", state, 2'd1);
      check("t2_item_clr", item_count, 32'd0);
      for (int k = 0; k <= 8; k++) begin
         pc = 64'h0FF8 + 64'(4 * k);
         pc_valid = 1'b1;
         #1;
         check("t2_state", state, (k <= 2) ? 2'd1 : ((k <= 6) ? 2'd2 : 2'd3));
         check("t2_filter", filter_pc_valid, (k >= 2 && k <= 6) ? 1'b1 : 1'b0);
         tick();
      end
      pc_valid = 1'b0;
      tick();
      check("t2_nfilt", 64'(filt_log.size() - fb), 64'd5);
      check("t2_nwr", 64'(wr_log.size() - wb), 64'd5);
      for (int k = 0; k < 5; k++) begin
         check("t2_wr_data", logged(wb + k), 64'h1000 + 64'(4 * k));
      end
      check("t2_done_cnt", 64'(done_cnt - db), 64'd1);
      check("t2_item", item_count, 32'd5);
      pulse_stop();
      cfg_trigger_en = 1'b0;

      // 3: item limit of 3 with stage 1 still occupied at the limit
      cfg_max_items = 32'd3;
      wb = wr_log.size(); db = done_cnt;
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         pc = 64'h200 + 64'(4 * k);
         pc_valid = 1'b1;
         #1;
         if (k == 4) begin
            check("t3_no4th_wr", fifo_wr_en, 1'b0);
            check("t3_state_k4", state, 2'd3);
         end
         tick();
      end
      pc_valid = 1'b0;
      tick(); tick();
      check("t3_nwr", 64'(wr_log.size() - wb), 64'd3);
      check("t3_item", item_count, 32'd3);
      check("t3_state", state, 2'd3);
      check("t3_done_cnt", 64'(done_cnt - db), 64'd1);
      for (int k = 0; k < 3; k++) begin
         check("t3_wr_data", logged(wb + k), 64'h200 + 64'(4 * k));
      end
      pulse_stop();
      cfg_max_items = 32'd0;

      // 4: FIFO full losses and saturation
      wb = wr_log.size();
      pulse_start();
      fifo_full = 1'b1;
      present(4, 64'h400);
      check("t4_nwr", 64'(wr_log.size() - wb), 64'd0);
      check("t4_ovf4", overflow_count, 16'd4);
      check("t4_small4", s_overflow_count, 3'd4);
      present(2, 64'h500);
      check("t4_small_preset", s_overflow_count, 3'd6);
      present(5, 64'h600);
      check("t4_ovf11", overflow_count, 16'd11);
      check("t4_small_sat", s_overflow_count, 3'd7);
      fifo_full = 1'b0;
      pulse_stop();
      pulse_stop();

      // 5: start and stop together in IDLE
      cfg_start = 1'b1;
      cfg_stop = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      #2;
      check("t5_state", state, 2'd0);
      check("t5_ovf", overflow_count, 16'd11);
      check("t5_small_ovf", s_overflow_count, 3'd7);

      // 6: asynchronous reset while stage 1 holds a kept item
      pulse_start();
      pc = 64'h2F0; pc_valid = 1'b1;
      tick();
      pc = 64'h300;
      tick();
      pc_valid = 1'b0;
      #1;
      check("t6_pre_item", item_count, 32'd1);
      check("t6_pre_wr", fifo_wr_en, 1'b1);
      wb = wr_log.size();
      rst_n = 1'b0;
      #1;
      check("t6_rst_state", state, 2'd0);
      check("t6_rst_wr_en", fifo_wr_en, 1'b0);
      check("t6_rst_wr_data", fifo_wr_data, 64'd0);
      check("t6_rst_item", item_count, 32'd0);
      check("t6_rst_busy", busy, 1'b0);
      #3;
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("t6_no_wr", 64'(wr_log.size() - wb), 64'd0);
      check("t6_state", state, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
